// File: rtl/irq_pend_ctrl_if.sv
// irq_pend_ctrl_if
// Bundles the request, handshake and status signals of the interrupt
// pending stage.
//   master : the side that drives requests, mask, enable and ack
//            (the consumer/environment).
//   slave  : the irq_pend_ctrl block itself.
// Signals:
//   req[7:0]       request lines, a 0->1 transition is an event
//   mask[7:0]      per-line presentation enable
//   en             global enable for starting a new presentation
//   irq_valid      an index is being presented
//   irq_id[2:0]    presented index, meaningful while irq_valid=1
//   irq_ack        consumer accepts the presented index
//   pend[7:0]      current pending register
//   irq_lost[7:0]  one-cycle pulse: event on a line already pending
interface irq_pend_ctrl_if;
    logic [7:0] req;
    logic [7:0] mask;
    logic       en;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       irq_ack;
    logic [7:0] pend;
    logic [7:0] irq_lost;

    modport master (
        output req, mask, en, irq_ack,
        input  irq_valid, irq_id, pend, irq_lost
    );

    modport slave (
        input  req, mask, en, irq_ack,
        output irq_valid, irq_id, pend, irq_lost
    );
endinterface

// File: rtl/irq_pend_ctrl.sv
// irq_pend_ctrl
// Edge-detects eight request lines into a pending register and presents
// the highest-numbered unmasked pending line on a valid/ack handshake.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    irq_pend_ctrl_if.slave (req, mask, en, irq_ack in;
//          irq_valid, irq_id, pend, irq_lost out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing presented; picks highest pend&mask when en=1
// PRESENT | irq_id held on irq_valid until irq_ack, no preemption
module irq_pend_ctrl (
    input  logic            clk,
    input  logic            rst_n,
    irq_pend_ctrl_if.slave  bus
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t     state;
    logic       valid_q;
    logic [2:0] id_q;
    logic [7:0] req_q;
    logic [7:0] pend_q;
    logic [7:0] lost_q;

    logic [7:0] rise;
    logic [7:0] clr;
    logic [7:0] cand;
    logic [2:0] sel_id;

    assign rise = bus.req & ~req_q;
    assign cand = pend_q & bus.mask;

    // Bit being acknowledged this cycle; only a live presentation can clear.
    always_comb begin
        clr = '0;
        if (valid_q && bus.irq_ack)
            clr[id_q] = 1'b1;
    end

    // Highest set index wins: later iterations overwrite earlier ones.
    always_comb begin
        sel_id = '0;
        for (int i = 0; i < 8; i++)
            if (cand[i])
                sel_id = 3'(i);
    end

    // A rise on the bit being cleared re-arms it (new event, not lost).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= '0;
            pend_q <= '0;
            lost_q <= '0;
        end else begin
            req_q  <= bus.req;
            pend_q <= (pend_q & ~clr) | rise;
            lost_q <= rise & pend_q & ~clr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en && (cand != 8'h00)) begin
                        id_q    <= sel_id;
                        valid_q <= 1'b1;
                        state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.irq_ack) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.irq_valid = valid_q;
    assign bus.irq_id    = id_q;
    assign bus.pend      = pend_q;
    assign bus.irq_lost  = lost_q;

endmodule

// File: tb/tb_irq_pend_ctrl.sv
module tb_irq_pend_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    irq_pend_ctrl_if bus ();

    irq_pend_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       en;
        logic       ack;
        logic       exp_valid;
        logic [2:0] exp_id;
        logic [7:0] exp_pend;
        logic [7:0] exp_lost;
    } vec_t;

    typedef struct {
        logic       valid;
        logic [2:0] id;
        logic [7:0] pend;
        logic [7:0] lost;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic [7:0] req, logic [7:0] mask, logic en, logic ack,
                                logic ev, logic [2:0] eid, logic [7:0] ep, logic [7:0] el);
        vec_t v;
        v.req = req; v.mask = mask; v.en = en; v.ack = ack;
        v.exp_valid = ev; v.exp_id = eid; v.exp_pend = ep; v.exp_lost = el;
        return v;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs,
    // then pop and compare once the DUT has clocked.
    task automatic cyc(input vec_t v);
        exp_t e;
        bus.req     = v.req;
        bus.mask    = v.mask;
        bus.en      = v.en;
        bus.irq_ack = v.ack;
        e.valid = v.exp_valid; e.id = v.exp_id; e.pend = v.exp_pend; e.lost = v.exp_lost;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check8("irq_valid", {7'b0, bus.irq_valid}, {7'b0, e.valid});
        if (e.valid)
            check8("irq_id", {5'b0, bus.irq_id}, {5'b0, e.id});
        check8("pend", bus.pend, e.pend);
        check8("irq_lost", bus.irq_lost, e.lost);
    endtask

    initial begin
        logic [7:0] p;

        // reset / first event
        vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00));
        vecs.push_back(mk(8'h04, 8'hFF, 1, 0, 0, 0, 8'h04, 8'h00));
        vecs.push_back(mk(8'h04, 8'hFF, 1, 0, 1, 2, 8'h04, 8'h00));
        vecs.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 0, 8'h00, 8'h00));
        vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00));
        // priority 7,4,0 with bubbles
        vecs.push_back(mk(8'h91, 8'hFF, 1, 0, 0, 0, 8'h91, 8'h00));
        vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 7, 8'h91, 8'h00));
        vecs.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 0, 8'h11, 8'h00));
        vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 4, 8'h11, 8'h00));
        vecs.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 0, 8'h01, 8'h00));
        vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 0, 8'h01, 8'h00));
        vecs.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 0, 8'h00, 8'h00));
        vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00));
        // masking
        vecs.push_back(mk(8'h80, 8'h7F, 1, 0, 0, 0, 8'h80, 8'h00));
        vecs.push_back(mk(8'h80, 8'h7F, 1, 0, 0, 0, 8'h80, 8'h00));
        vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 7, 8'h80, 8'h00));
        vecs.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 0, 8'h00, 8'h00));
        // en=0 holds off presentation, stray ack ignored
        vecs.push_back(mk(8'h02, 8'hFF, 0, 0, 0, 0, 8'h02, 8'h00));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(8'h02, 8'hFF, 0, (i == 5), 0, 0, 8'h02, 8'h00));
        vecs.push_back(mk(8'h02, 8'hFF, 1, 0, 1, 1, 8'h02, 8'h00));
        // no preemption; en/mask drop does not withdraw
        vecs.push_back(mk(8'h42, 8'hFF, 1, 0, 1, 1, 8'h42, 8'h00));
        vecs.push_back(mk(8'h42, 8'h00, 0, 0, 1, 1, 8'h42, 8'h00));
        vecs.push_back(mk(8'h42, 8'hFF, 1, 1, 0, 0, 8'h40, 8'h00));
        vecs.push_back(mk(8'h42, 8'hFF, 1, 0, 1, 6, 8'h40, 8'h00));
        vecs.push_back(mk(8'h42, 8'hFF, 1, 1, 0, 0, 8'h00, 8'h00));
        // lost pulse on second rise of line 3
        vecs.push_back(mk(8'h08, 8'hFF, 1, 0, 0, 0, 8'h08, 8'h00));
        vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 3, 8'h08, 8'h00));
        vecs.push_back(mk(8'h08, 8'hFF, 1, 0, 1, 3, 8'h08, 8'h08));
        vecs.push_back(mk(8'h08, 8'hFF, 1, 0, 1, 3, 8'h08, 8'h00));
        vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 3, 8'h08, 8'h00));
        // set wins over ack-clear on line 3
        vecs.push_back(mk(8'h08, 8'hFF, 1, 1, 0, 0, 8'h08, 8'h00));
        vecs.push_back(mk(8'h00, 8'hFF, 1, 0, 1, 3, 8'h08, 8'h00));
        vecs.push_back(mk(8'h00, 8'hFF, 1, 1, 0, 0, 8'h00, 8'h00));

        bus.req = 8'h00; bus.mask = 8'hFF; bus.en = 1'b1; bus.irq_ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check8("rst_valid", {7'b0, bus.irq_valid}, 8'h00);
        check8("rst_id", {5'b0, bus.irq_id}, 8'h00);
        check8("rst_pend", bus.pend, 8'h00);
        check8("rst_lost", bus.irq_lost, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            cyc(vecs[i]);

        // reset mid-PRESENT with everything pending
        cyc(mk(8'hFF, 8'hFF, 1, 0, 0, 0, 8'hFF, 8'h00));
        cyc(mk(8'hFF, 8'hFF, 1, 0, 1, 7, 8'hFF, 8'h00));
        #3;
        rst_n = 1'b0;
        #1;
        check8("async_valid", {7'b0, bus.irq_valid}, 8'h00);
        check8("async_pend", bus.pend, 8'h00);
        check8("async_lost", bus.irq_lost, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // req held high across release: every line pends from req_q=0
        cyc(mk(8'hFF, 8'hFF, 1, 0, 0, 0, 8'hFF, 8'h00));
        cyc(mk(8'hFF, 8'hFF, 1, 0, 1, 7, 8'hFF, 8'h00));
        p = 8'hFF;
        for (int i = 7; i >= 0; i--) begin
            p[i] = 1'b0;
            cyc(mk(8'hFF, 8'hFF, 1, 1, 0, 0, p, 8'h00));
            if (i > 0)
                cyc(mk(8'hFF, 8'hFF, 1, 0, 1, 3'(i - 1), p, 8'h00));
        end
        cyc(mk(8'hFF, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
